// File: rtl/outerprodrc_ctrl_pkg.sv
// Shared types and helpers for the outer-product array sequencer.
package outerprodrc_ctrl_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_LOAD  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Single-bit controls that are a pure function of the state.
  typedef struct packed {
    logic req_ready;
    logic load;
    logic arr_clr;
    logic arr_en;
    logic busy;
    logic resp_valid;
  } ctrl_out_t;

  // Unary stream length for an operand width of bw bits.
  function automatic int stream_len(input int bw);
    return 1 << bw;
  endfunction

endpackage

// File: rtl/outerprodrc_ctrl_if.sv
// Job/response handshake and array control bundle between the sequencer and its environment.
interface outerprodrc_ctrl_if #(
  parameter int TILEW = 4
);
  logic             iReqValid;
  logic             oReqReady;
  logic [TILEW-1:0] iTileNum;
  logic             iAbort;
  logic             oLoad;
  logic [TILEW-1:0] oTileIdx;
  logic             oArrClr;
  logic             oArrEn;
  logic             oBusy;
  logic             oRespValid;
  logic             iRespReady;

  // Controller side.
  modport slave (
    input  iReqValid, iTileNum, iAbort, iRespReady,
    output oReqReady, oLoad, oTileIdx, oArrClr, oArrEn, oBusy, oRespValid
  );

  // Job source / result consumer side.
  modport master (
    output iReqValid, iTileNum, iAbort, iRespReady,
    input  oReqReady, oLoad, oTileIdx, oArrClr, oArrEn, oBusy, oRespValid
  );
endinterface

// File: rtl/outerprodrc_ctrl_cnt.sv
// Loadable down-counter that stops at zero and flags the terminal count.
module outerprodrc_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;

  // Load has priority over counting; the count saturates at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/outerprodrc_ctrl.sv
// Sequencer for the unary outer-product array: clear, stream each operand
// tile for one stream length, drain the array pipeline, hand off the result.
module outerprodrc_ctrl
  import outerprodrc_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int TILEW    = 4,
  parameter int PIPE_LAT = 1
) (
  input  logic               iClk,
  input  logic               iRstN,
  outerprodrc_ctrl_if.slave  bus
);
  localparam int L        = stream_len(BITWIDTH);
  localparam int DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DRAIN_IV = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

  localparam logic [BITWIDTH-1:0] RUN_INIT   = BITWIDTH'(L - 1);
  localparam logic [DW-1:0]       DRAIN_INIT = DW'(DRAIN_IV);

  state_e           state_q, state_d;
  ctrl_out_t        out_q, out_d;
  logic [TILEW-1:0] tile_idx_q, tile_idx_d;
  logic [TILEW-1:0] tnum_q, tnum_d;

  logic accept;
  logic last_tile;
  logic run_tc;
  logic drain_tc;

  assign accept    = out_q.req_ready & bus.iReqValid;
  assign last_tile = (tile_idx_q == (tnum_q - 1'b1));

  // Stream-length counter: preloaded to L-1 outside RUN, counts down through RUN.
  outerprodrc_ctrl_cnt #(
    .W (BITWIDTH)
  ) u_run_cnt (
    .clk        (iClk),
    .rst_n      (iRstN),
    .load_i     (state_q != S_RUN),
    .load_val_i (RUN_INIT),
    .en_i       (state_q == S_RUN),
    .tc_o       (run_tc)
  );

  // Drain counter exists only when the array has output latency.
  generate
    if (PIPE_LAT > 0) begin : g_drain
      outerprodrc_ctrl_cnt #(
        .W (DW)
      ) u_drain_cnt (
        .clk        (iClk),
        .rst_n      (iRstN),
        .load_i     (state_q != S_DRAIN),
        .load_val_i (DRAIN_INIT),
        .en_i       (state_q == S_DRAIN),
        .tc_o       (drain_tc)
      );
    end else begin : g_no_drain
      assign drain_tc = 1'b1;
    end
  endgenerate

  // State, registered outputs, tile index and latched tile count.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= S_IDLE;
      out_q      <= '{req_ready: 1'b1, default: 1'b0};
      tile_idx_q <= '0;
      tnum_q     <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      tile_idx_q <= tile_idx_d;
      tnum_q     <= tnum_d;
    end
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (run_tc) begin
          if (last_tile) state_d = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
          else           state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_DRAIN: if (drain_tc) state_d = S_DONE;
      S_DONE:  if (bus.iRespReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.iAbort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Tile index follows the next state so it lines up with the registered controls.
  always_comb begin
    tnum_d     = tnum_q;
    tile_idx_d = tile_idx_q;
    if (accept) tnum_d = (bus.iTileNum == '0) ? TILEW'(1) : bus.iTileNum;
    if ((state_d == S_IDLE) || (state_d == S_CLEAR)) begin
      tile_idx_d = '0;
    end else if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
      tile_idx_d = tile_idx_q + 1'b1;
    end
  end

  // Moore output decode of the next state, registered above.
  always_comb begin
    out_d            = '0;
    out_d.req_ready  = (state_d == S_IDLE);
    out_d.busy       = (state_d != S_IDLE);
    out_d.arr_clr    = (state_d == S_CLEAR);
    out_d.load       = (state_d == S_CLEAR) || (state_d == S_LOAD);
    out_d.arr_en     = (state_d == S_RUN);
    out_d.resp_valid = (state_d == S_DONE);
  end

  assign bus.oReqReady  = out_q.req_ready;
  assign bus.oLoad      = out_q.load;
  assign bus.oTileIdx   = tile_idx_q;
  assign bus.oArrClr    = out_q.arr_clr;
  assign bus.oArrEn     = out_q.arr_en;
  assign bus.oBusy      = out_q.busy;
  assign bus.oRespValid = out_q.resp_valid;
endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Self-checking bench for outerprodrc_ctrl with a cycle-level reference model.
module tb_outerprodrc_ctrl;
  localparam int BITWIDTH = 2;
  localparam int TILEW    = 4;
  localparam int PIPE_LAT = 1;
  localparam int L        = 1 << BITWIDTH;

  typedef struct packed {
    logic             ready;
    logic             busy;
    logic             clr;
    logic             load;
    logic             en;
    logic             resp;
    logic [TILEW-1:0] idx;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  outerprodrc_ctrl_if #(.TILEW(TILEW)) bus ();

  outerprodrc_ctrl #(
    .BITWIDTH (BITWIDTH),
    .TILEW    (TILEW),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic obs_t observe();
    obs_t o;
    o.ready = bus.oReqReady;
    o.busy  = bus.oBusy;
    o.clr   = bus.oArrClr;
    o.load  = bus.oLoad;
    o.en    = bus.oArrEn;
    o.resp  = bus.oRespValid;
    o.idx   = bus.oTileIdx;
    return o;
  endfunction

  function automatic obs_t reset_exp();
    obs_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected outputs c cycles after acceptance of a T-tile job (c >= 1).
  // Timeline: 1 clear cycle, then T tiles of L enable cycles separated by one
  // load cycle, then PIPE_LAT drain cycles, then the result phase.
  function automatic obs_t job_exp(input int c, input int t);
    obs_t e = '0;
    int run_end, off, k, r;
    run_end = 1 + t * L + (t - 1);
    e.busy  = 1'b1;
    if (c == 1) begin
      e.clr  = 1'b1;
      e.load = 1'b1;
    end else if (c <= run_end) begin
      off = c - 2;
      k   = off / (L + 1);
      r   = off % (L + 1);
      if (r < L) begin
        e.en  = 1'b1;
        e.idx = TILEW'(k);
      end else begin
        e.load = 1'b1;
        e.idx  = TILEW'(k + 1);
      end
    end else if (c <= run_end + PIPE_LAT) begin
      e.idx = TILEW'(t - 1);
    end else begin
      e.resp = 1'b1;
      e.idx  = TILEW'(t - 1);
    end
    return e;
  endfunction

  function automatic int done_cycle(input int t);
    return 2 + t * L + (t - 1) + PIPE_LAT;
  endfunction

  // Runs one job from acceptance to its return to IDLE, comparing every cycle.
  // hold: DONE cycles with iRespReady low. abort_at: cycle to assert iAbort (0 = never).
  task automatic run_job(input int tnum, input int hold, input int abort_at, input string tag);
    obs_t act, exp;
    int   t, done_c, en_seen;
    t       = (tnum == 0) ? 1 : tnum;
    done_c  = done_cycle(t);
    en_seen = 0;
    @(negedge clk);
    act = observe();
    checks++;
    if (act.ready !== 1'b1 || act.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before_job: ready=%b busy=%b required ready=1 busy=0", tag, act.ready, act.busy);
    end
    bus.iReqValid = 1'b1;
    bus.iTileNum  = TILEW'(tnum);
    for (int c = 1; c <= done_c + hold + 1; c++) begin
      @(negedge clk);
      bus.iReqValid  = 1'($urandom_range(0, 1));
      bus.iTileNum   = TILEW'($urandom);
      bus.iAbort     = 1'b0;
      bus.iRespReady = 1'b0;
      act = observe();
      if ((abort_at > 0 && c == abort_at + 1) || (abort_at == 0 && c == done_c + hold + 1)) begin
        bus.iReqValid = 1'b0;
        exp = reset_exp();
        checks++;
        if ({act.ready, act.busy, act.clr, act.load, act.en, act.resp} !==
            {exp.ready, exp.busy, exp.clr, exp.load, exp.en, exp.resp}) begin
          errors++;
          $display("FAIL %s back_to_idle c=%0d: rdy/busy/clr/load/en/resp=%b%b%b%b%b%b required 100000",
                   tag, c, act.ready, act.busy, act.clr, act.load, act.en, act.resp);
        end
        break;
      end
      exp = job_exp(c, t);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cycle c=%0d: got rdy=%b busy=%b clr=%b load=%b en=%b resp=%b idx=%0d required rdy=%b busy=%b clr=%b load=%b en=%b resp=%b idx=%0d",
                 tag, c, act.ready, act.busy, act.clr, act.load, act.en, act.resp, act.idx,
                 exp.ready, exp.busy, exp.clr, exp.load, exp.en, exp.resp, exp.idx);
      end
      if (act.en === 1'b1) en_seen++;
      if (c < done_c) bus.iRespReady = 1'($urandom_range(0, 1));
      if (c == abort_at) begin
        bus.iAbort = 1'b1;
        if (c >= done_c) bus.iRespReady = 1'($urandom_range(0, 1));
      end else if (c >= done_c && c == done_c + hold) begin
        bus.iRespReady = 1'b1;
      end
    end
    if (abort_at == 0) begin
      checks++;
      if (en_seen != t * L) begin
        errors++;
        $display("FAIL %s enable_count: got %0d required %0d", tag, en_seen, t * L);
      end
    end
    bus.iAbort     = 1'b0;
    bus.iRespReady = 1'b0;
  endtask

  task automatic test_reset();
    obs_t act;
    @(negedge clk);
    act = observe();
    checks++;
    if (act !== reset_exp()) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", act, reset_exp());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();   run_job(1, 0, 0, "single_tile");  endtask
  task automatic test_three_tiles();   run_job(3, 0, 0, "three_tiles");  endtask
  task automatic test_zero_tiles();    run_job(0, 0, 0, "zero_tiles");   endtask
  task automatic test_max_tiles();     run_job(15, 1, 0, "max_tiles");   endtask
  task automatic test_backpressure();  run_job(1, 5, 0, "backpressure"); endtask

  task automatic test_abort();
    // Third RUN cycle of tile 1 with T=3 is cycle 9 after acceptance.
    run_job(3, 0, 9, "abort_run");
    run_job(2, 0, 0, "after_abort");
  endtask

  task automatic test_idle_abort();
    obs_t act;
    @(negedge clk);
    bus.iReqValid = 1'b1;
    bus.iTileNum  = TILEW'(1);
    bus.iAbort    = 1'b1;
    @(negedge clk);
    bus.iReqValid = 1'b0;
    act = observe();
    checks++;
    if (act.clr !== 1'b1 || act.ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_ignored: clr=%b ready=%b required clr=1 ready=0", act.clr, act.ready);
    end
    @(negedge clk);
    bus.iAbort = 1'b0;
    act = observe();
    checks++;
    if (act.ready !== 1'b1 || act.busy !== 1'b0 || act.en !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_clear: ready=%b busy=%b en=%b required 1 0 0", act.ready, act.busy, act.en);
    end
  endtask

  task automatic test_async_reset();
    obs_t act;
    @(negedge clk);
    bus.iReqValid = 1'b1;
    bus.iTileNum  = TILEW'(2);
    @(negedge clk);
    bus.iReqValid = 1'b0;
    repeat (2) @(negedge clk);
    act = observe();
    checks++;
    if (act.en !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_setup: en=%b required 1", act.en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = observe();
    checks++;
    if (act !== reset_exp()) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h required %h", act, reset_exp());
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    int tnum, hold, abort_at;
    for (int j = 0; j < 24; j++) begin
      tnum     = $urandom_range(0, 15);
      hold     = $urandom_range(0, 4);
      abort_at = 0;
      if ($urandom_range(0, 3) == 0)
        abort_at = $urandom_range(1, done_cycle((tnum == 0) ? 1 : tnum) + hold);
      run_job(tnum, hold, abort_at, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.iReqValid  = 1'b0;
    bus.iTileNum   = '0;
    bus.iAbort     = 1'b0;
    bus.iRespReady = 1'b0;
    test_reset();
    test_single_tile();
    test_three_tiles();
    test_zero_tiles();
    test_max_tiles();
    test_backpressure();
    test_abort();
    test_idle_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
